// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the UART transmitter.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  localparam logic PAR_EVEN    = 1'b1;
  localparam logic PAR_ODD     = 1'b0;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity bit for a data word; even type makes the total ones count even.
module uart_tx_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] data,
  input  logic                 par_typ,
  output logic                 par_bit
);

  assign par_bit = (par_typ == PAR_EVEN) ? (^data) : ~(^data);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter, one bit per CLK, LSB first, optional parity.
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx_core
  import uart_tx_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATAWIDTH-1:0] P_DATA,
  input  logic                 DATA_VALID,
  input  logic                 PAR_EN,
  input  logic                 PAR_TYP,
  output logic                 TX_OUT,
  output logic                 BUSY
);

  localparam int CNT_W = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATAWIDTH - 1);

  state_e               state_q, state_d;
  logic [DATAWIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 tx_q, tx_d;
  logic                 par_calc;
`ifdef UART_TX_TWO_STOP_EN
  logic                 stop_cnt_q, stop_cnt_d;
`endif

  // Parity is taken from the incoming word at acceptance, since the shift register consumes it.
  uart_tx_parity_calc #(.DATAWIDTH(DATAWIDTH)) u_par (
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .par_bit (par_calc)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (DATA_VALID) state_d = ST_START;
      ST_START:  state_d = ST_DATA;
      ST_DATA:   if (cnt_q == CNT_LAST) state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: state_d = ST_STOP;
`ifdef UART_TX_TWO_STOP_EN
      ST_STOP:   state_d = stop_cnt_q ? ST_IDLE : ST_STOP;
`else
      ST_STOP:   state_d = ST_IDLE;
`endif
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_d      = IDLE_LEVEL;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    case (state_q)
      ST_IDLE: begin
        if (DATA_VALID) begin
          shreg_d   = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = par_calc;
          cnt_d     = '0;
        end
      end
      ST_START:  tx_d = START_LEVEL;
      ST_DATA: begin
        tx_d    = shreg_q[0];
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_PARITY: tx_d = par_bit_q;
      ST_STOP:   tx_d = STOP_LEVEL;
      default:   tx_d = IDLE_LEVEL;
    endcase
  end

`ifdef UART_TX_TWO_STOP_EN
  assign stop_cnt_d = (state_q == ST_STOP) ? ~stop_cnt_q : 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_q      <= IDLE_LEVEL;
      shreg_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_q <= 1'b0;
`endif
    end else begin
      tx_q      <= tx_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_q <= stop_cnt_d;
`endif
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: driver predicts frames, monitor decodes the line.
module tb_uart_tx_core;
  localparam int W = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] p_data = '0;
  logic         dv = 1'b0, pe = 1'b0, pt = 1'b0;
  logic         tx, busy;

  uart_tx_core #(.DATAWIDTH(W)) dut (
    .CLK(clk), .RST(rst), .P_DATA(p_data), .DATA_VALID(dv),
    .PAR_EN(pe), .PAR_TYP(pt), .TX_OUT(tx), .BUSY(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W+3:0] bits;
    int           nbits;
    int           start_edge;
  } frame_t;

  frame_t exp_q[$];
  int idle_edge = 0;   // last edge after which the transmitter is still busy
  int checks = 0, errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic frame_t mk(input logic [W-1:0] d, input logic pe_i, input logic pt_i, input int se);
    frame_t f;
    int k;
    int ones;
    ones = $countones(d);
    f.bits = '0;
    f.bits[0] = 1'b0;
    for (int i = 0; i < W; i++) f.bits[1+i] = d[i];
    k = 1 + W;
    if (pe_i) begin
      f.bits[k] = pt_i ? (ones % 2 == 1) : (ones % 2 == 0);
      k++;
    end
    for (int s = 0; s < NSTOP; s++) begin
      f.bits[k] = 1'b1;
      k++;
    end
    f.nbits = k;
    f.start_edge = se;
    return f;
  endfunction

  // Called at a negedge; strobes for exactly the next rising edge.
  task automatic send(input logic [W-1:0] d, input logic pe_i, input logic pt_i);
    int e;
    e = cyc + 1;
    p_data = d; pe = pe_i; pt = pt_i; dv = 1'b1;
    if (!rst && e > idle_edge) begin
      exp_q.push_back(mk(d, pe_i, pt_i, e + 1));
      idle_edge = e + W + 1 + int'(pe_i) + NSTOP;
    end
    @(negedge clk);
    dv = 1'b0;
    p_data = W'($urandom); pe = 1'($urandom); pt = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_free();
    while (cyc + 1 <= idle_edge) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle_edge = 0;
    idle(n);
    rst = 1'b0;
  endtask

  initial begin : monitor
    frame_t cur;
    int idx;
    bit inf;
    int n;
    inf = 0;
    idx = 0;
    forever begin
      @(posedge clk);
      #1;
      n = cyc;
      if (rst) begin
        inf = 0;
        exp_q.delete();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
      end else begin
        check("busy", 32'(busy), 32'(n < idle_edge));
        if (!inf) begin
          if (tx === 1'b0) begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_start at edge %0d: got start bit expected idle", n);
            end else begin
              cur = exp_q.pop_front();
              check("start_edge", 32'(n), 32'(cur.start_edge));
              idx = 1;
              inf = 1;
            end
          end else begin
            check("idle_level", 32'(tx), 32'd1);
          end
        end else begin
          check($sformatf("bit%0d", idx), 32'(tx), 32'(cur.bits[idx]));
          idx++;
          if (idx == cur.nbits) inf = 0;
        end
      end
    end
  end

  initial begin : stim
    @(negedge clk);
    do_reset(2);

    send(8'h55, 1'b1, 1'b1);        wait_free();
    send(8'd100, 1'b0, 1'b0);       wait_free();
    send(8'b10011001, 1'b1, 1'b0);  wait_free();
    idle(3);

    // back-to-back: second strobe lands on the stop-bit cycle
    send(8'b11001011, 1'b1, 1'b1);  wait_free();
    send(8'b10011011, 1'b0, 1'b0);  wait_free();
    idle(2);

    // strobe mid-frame must be ignored
    send(8'hA3, 1'b1, 1'b0);
    idle(4);
    send(8'h3C, 1'b0, 1'b1);
    wait_free();
    idle(2);

    // reset mid-frame aborts
    send(8'hF0, 1'b1, 1'b1);
    idle(5);
    do_reset(1);
    idle(3);

    for (int t = 0; t < 60; t++) begin
      idle($urandom_range(0, W + 4));
      if ($urandom_range(0, 11) == 0) do_reset(1);
      else send(W'($urandom), 1'($urandom), 1'($urandom));
    end

    wait_free();
    idle(W + 8);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
